// File: rtl/pipe_div.sv
// Fully pipelined unsigned restoring divider: NSTAGE registered stages, each resolving
// TBIT/NSTAGE quotient bits. One operation accepted per cycle, results in issue order.
module pipe_div #(
   parameter int unsigned TBIT   = 64,
   parameter int unsigned NSTAGE = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [TBIT-1:0] dividend,
   input  logic [TBIT-1:0] divisor,
   output logic [TBIT-1:0] quotient,
   output logic [TBIT-1:0] remainder,
   output logic            dbz,
   output logic            done
);

   localparam int unsigned STEP = TBIT / NSTAGE;

   // rem is one bit wider than the operands so a shifted remainder never overflows
   // when the divisor has its MSB set.
   typedef struct packed {
      logic [TBIT:0]   rem;
      logic [TBIT-1:0] dnd;
      logic [TBIT-1:0] quo;
   } part_t;

   function automatic part_t div_step(input part_t p, input logic [TBIT-1:0] dvs);
      part_t r;
      logic  ge;
      r = p;
      for (int unsigned i = 0; i < STEP; i++) begin
         r.rem = {r.rem[TBIT-1:0], r.dnd[TBIT-1]};
         r.dnd = r.dnd << 1;
         ge    = (r.rem >= {1'b0, dvs});
         if (ge) begin
            r.rem = r.rem - {1'b0, dvs};
         end
         r.quo = {r.quo[TBIT-2:0], ge};
      end
      return r;
   endfunction

   logic [NSTAGE-1:0] vld_q;
   logic [NSTAGE-1:0] dbz_q;
   logic [TBIT-1:0]   dvs_q [NSTAGE];
   part_t             part_q [NSTAGE];

   logic [NSTAGE-1:0] vld_in;
   logic [NSTAGE-1:0] dbz_in;
   logic [TBIT-1:0]   dvs_in [NSTAGE];
   part_t             part_in [NSTAGE];
   part_t             part_d [NSTAGE];

   always_comb begin
      vld_in         = '0;
      dbz_in         = '0;
      vld_in[0]      = start;
      dbz_in[0]      = (divisor == '0);
      dvs_in[0]      = divisor;
      part_in[0].rem = '0;
      part_in[0].dnd = dividend;
      part_in[0].quo = '0;
      for (int s = 1; s < NSTAGE; s++) begin
         vld_in[s]  = vld_q[s-1];
         dbz_in[s]  = dbz_q[s-1];
         dvs_in[s]  = dvs_q[s-1];
         part_in[s] = part_q[s-1];
      end
      for (int s = 0; s < NSTAGE; s++) begin
         part_d[s] = div_step(part_in[s], dvs_in[s]);
      end
   end

   // Datapath registers only load for valid slots; bubbles leave them untouched.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_q <= '0;
         dbz_q <= '0;
         for (int s = 0; s < NSTAGE; s++) begin
            dvs_q[s]  <= '0;
            part_q[s] <= '0;
         end
      end else begin
         vld_q <= vld_in;
         for (int s = 0; s < NSTAGE; s++) begin
            if (vld_in[s]) begin
               dbz_q[s]  <= dbz_in[s];
               dvs_q[s]  <= dvs_in[s];
               part_q[s] <= part_d[s];
            end
         end
      end
   end

   assign done      = vld_q[NSTAGE-1];
   assign dbz       = vld_q[NSTAGE-1] & dbz_q[NSTAGE-1];
   assign quotient  = vld_q[NSTAGE-1] ? part_q[NSTAGE-1].quo : '0;
   assign remainder = vld_q[NSTAGE-1] ? part_q[NSTAGE-1].rem[TBIT-1:0] : '0;

   // Last stage's leftover dividend bits, remainder MSB and divisor are not needed.
   logic unused_tail;
   assign unused_tail = ^{part_q[NSTAGE-1].dnd, part_q[NSTAGE-1].rem[TBIT], dvs_q[NSTAGE-1]};

endmodule

// File: tb/tb_pipe_div.sv
// Bench for pipe_div: arithmetic reference model with a per-cycle compare process,
// plus directed literal cases, a random stream with bubbles and a mid-flight reset.
module tb_pipe_div;

   localparam int unsigned TBIT   = 64;
   localparam int unsigned NSTAGE = 8;

   logic            clock = 1'b0;
   logic            reset;
   logic            start;
   logic [TBIT-1:0] dividend;
   logic [TBIT-1:0] divisor;
   logic [TBIT-1:0] quotient;
   logic [TBIT-1:0] remainder;
   logic            dbz;
   logic            done;

   pipe_div #(
      .TBIT   (TBIT),
      .NSTAGE (NSTAGE)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz),
      .done      (done)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   bit run = 1'b0;

   task automatic chk(input string name, input logic [TBIT-1:0] act, input logic [TBIT-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: each accepted op's result is computed arithmetically and delivered
   // NSTAGE edges later; non-accepted cycles deliver an empty slot.
   logic            exp_v [NSTAGE];
   logic [TBIT-1:0] exp_q [NSTAGE];
   logic [TBIT-1:0] exp_r [NSTAGE];
   logic            exp_z [NSTAGE];

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NSTAGE; i++) begin
            exp_v[i] <= 1'b0;
            exp_q[i] <= '0;
            exp_r[i] <= '0;
            exp_z[i] <= 1'b0;
         end
      end else begin
         for (int i = NSTAGE - 1; i > 0; i--) begin
            exp_v[i] <= exp_v[i-1];
            exp_q[i] <= exp_q[i-1];
            exp_r[i] <= exp_r[i-1];
            exp_z[i] <= exp_z[i-1];
         end
         exp_v[0] <= start;
         if (divisor == '0) begin
            exp_q[0] <= '1;
            exp_r[0] <= dividend;
            exp_z[0] <= 1'b1;
         end else begin
            exp_q[0] <= dividend / divisor;
            exp_r[0] <= dividend % divisor;
            exp_z[0] <= 1'b0;
         end
      end
   end

   always @(negedge clock) begin
      if (run) begin
         chk("m_done", done, exp_v[NSTAGE-1]);
         if (exp_v[NSTAGE-1]) begin
            chk("m_quo", quotient, exp_q[NSTAGE-1]);
            chk("m_rem", remainder, exp_r[NSTAGE-1]);
            chk("m_dbz", dbz, exp_z[NSTAGE-1]);
         end else begin
            chk("m_quo_idle", quotient, '0);
            chk("m_rem_idle", remainder, '0);
            chk("m_dbz_idle", dbz, '0);
         end
         if (done) done_cnt++;
      end
   end

   // Called just after a rising edge; the op is captured on the next edge.
   task automatic issue(input logic [TBIT-1:0] a, input logic [TBIT-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clock);
      #1;
      start    = 1'b0;
      dividend = {$urandom, $urandom};
      divisor  = {$urandom, $urandom};
   endtask

   task automatic lit(input string name, input logic [TBIT-1:0] a, input logic [TBIT-1:0] b,
                      input logic [TBIT-1:0] eq, input logic [TBIT-1:0] er, input logic ez);
      issue(a, b);
      repeat (NSTAGE - 1) @(posedge clock);
      #1;
      chk({name, "_done"}, done, 1'b1);
      chk({name, "_quo"}, quotient, eq);
      chk({name, "_rem"}, remainder, er);
      chk({name, "_dbz"}, dbz, ez);
   endtask

   logic [TBIT-1:0] ra;
   logic [TBIT-1:0] rb;
   int              issued;
   int              cnt0;

   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      @(posedge clock);
      #1;
      run = 1'b1;
      chk("rst_done", done, 1'b0);
      chk("rst_quo", quotient, '0);
      chk("rst_rem", remainder, '0);
      chk("rst_dbz", dbz, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      lit("single", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0);
      @(posedge clock);
      #1;
      chk("single_after", done, 1'b0);

      lit("dbz", 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1);
      lit("max_by_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
      lit("max_by_msb", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd1,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
      lit("small", 64'd5, 64'd9, 64'd0, 64'd5, 1'b0);

      // Random stream, bubble on every third cycle.
      issued = 0;
      for (int c = 0; issued < 20; c++) begin
         if (c % 3 == 2) begin
            start    = 1'b0;
            dividend = {$urandom, $urandom};
            divisor  = {$urandom, $urandom};
            @(posedge clock);
            #1;
         end else begin
            ra = {$urandom, $urandom} >> $urandom_range(0, 40);
            rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) rb = '0;
            issue(ra, rb);
            issued++;
         end
      end
      repeat (NSTAGE + 2) @(posedge clock);
      #1;

      // Mid-flight reset: first op just completing, three more still inside.
      for (int i = 0; i < 4; i++) begin
         issue(64'd1000 + 64'(i), 64'd3);
      end
      repeat (NSTAGE - 4) @(posedge clock);
      #1;
      chk("pre_rst_done", done, 1'b1);
      reset = 1'b0;
      #1;
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_quo", quotient, '0);
      chk("mid_rst_rem", remainder, '0);
      chk("mid_rst_dbz", dbz, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      cnt0  = done_cnt;
      reset = 1'b1;
      lit("post_rst", 64'd30, 64'd4, 64'd7, 64'd2, 1'b0);
      @(negedge clock);
      #1;
      chk("post_rst_pulses", 64'(done_cnt - cnt0), 64'd1);
      repeat (3) @(posedge clock);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
